// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Control-word bit positions must track the decoder's ID/EX control layout.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } hazard_state_e;

    localparam int REG_WRITE_BIT = 0;
    localparam int MEM_READ_BIT  = 3;
    localparam int MUL_BIT       = 9;

    localparam logic [4:0] ZERO_REG = 5'd31;

    // X31 reads as zero, so a producer targeting it never creates a RAW hazard.
    function automatic logic src_hazard(input logic [4:0] rd,
                                        input logic [4:0] rs,
                                        input logic       used);
        return used && (rs == rd) && (rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mul_cycle_counter.sv
// 4-bit loadable down-counter that tracks the remaining multiply stall cycles.
// Load wins over hold; the count never wraps below zero.
module mul_cycle_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       hold,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (!hold && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes,
// multi-cycle multiply occupancy of EX, memory-wait freezes and a stall counter.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CTRL_W     = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ex_control,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              branch_taken,
    input  logic              mem_wait,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_bubble,
    output logic              ex_mem_en,
    output logic              ex_mem_bubble,
    output logic              mul_busy,
    output logic [31:0]       stall_cycles
);

    // The entry cycle in RUN and the release cycle in MUL_BUSY account for two
    // of the MUL_CYCLES, so only the remainder is counted down.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

    hazard_state_e state;
    hazard_state_e next_state;

    logic       mul_ex;
    logic       memrd_ex;
    logic       load_use;
    logic       cnt_load;
    logic       cnt_hold;
    logic       cnt_zero;
    logic [3:0] cnt;
    logic       unused_ctrl;

    assign mul_ex      = ex_control[MUL_BIT];
    assign memrd_ex    = ex_control[MEM_READ_BIT];
    assign load_use    = memrd_ex && (src_hazard(ex_rd, id_rs1, id_use_rs1) ||
                                      src_hazard(ex_rd, id_rs2, id_use_rs2));
    assign unused_ctrl = ^{ex_control, cnt};

    mul_cycle_counter u_mul_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (MUL_LOAD),
        .hold       (cnt_hold),
        .count      (cnt),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_en     = 1'b1;
        ex_mem_bubble = 1'b0;
        mul_busy      = 1'b0;
        cnt_load      = 1'b0;
        cnt_hold      = 1'b1;
        next_state    = state;

        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (mem_wait) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                    end else if (mul_ex) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        cnt_load      = 1'b1;
                        next_state    = MUL_BUSY;
                    end else if (branch_taken) begin
                        // The ID instruction is discarded, so its load-use hazard is moot.
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    mul_busy = 1'b1;
                    if (mem_wait) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                    end else if (!cnt_zero) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        cnt_hold      = 1'b0;
                    end else begin
                        next_state = RUN;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
        end else if (!pc_en && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MUL_CYCLES=4).
// Inputs change at negedge; combinational outputs are sampled 1ns later.
module tb_hazard_stall_ctrl;

    localparam int CTRL_W = 14;

    localparam logic [CTRL_W-1:0] C_NONE = 14'h0000;
    localparam logic [CTRL_W-1:0] C_LOAD = 14'h0008;
    localparam logic [CTRL_W-1:0] C_MUL  = 14'h0200;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, ex_mem_bubble, mul_busy}
    localparam logic [7:0] E_DEF  = 8'b1101_0100;
    localparam logic [7:0] E_LU   = 8'b0001_1100;
    localparam logic [7:0] E_MUL0 = 8'b0000_0110;
    localparam logic [7:0] E_MULB = 8'b0000_0111;
    localparam logic [7:0] E_REL  = 8'b1101_0101;
    localparam logic [7:0] E_MWR  = 8'b0000_0000;
    localparam logic [7:0] E_MWB  = 8'b0000_0001;
    localparam logic [7:0] E_BR   = 8'b1111_1100;

    logic              clk = 1'b0;
    logic              reset;
    logic [CTRL_W-1:0] ex_control;
    logic [4:0]        ex_rd;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              branch_taken;
    logic              mem_wait;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_bubble;
    logic              ex_mem_en;
    logic              ex_mem_bubble;
    logic              mul_busy;
    logic [31:0]       stall_cycles;

    int checks = 0;
    int passed = 0;

    hazard_stall_ctrl #(
        .MUL_CYCLES (4),
        .CTRL_W     (CTRL_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_control    (ex_control),
        .ex_rd         (ex_rd),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .branch_taken  (branch_taken),
        .mem_wait      (mem_wait),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_en      (id_ex_en),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_en     (ex_mem_en),
        .ex_mem_bubble (ex_mem_bubble),
        .mul_busy      (mul_busy),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic              rst,
                                 input logic [CTRL_W-1:0] ctrl,
                                 input logic [4:0]        rd,
                                 input logic [4:0]        rs1,
                                 input logic [4:0]        rs2,
                                 input logic              use1,
                                 input logic              use2,
                                 input logic              br,
                                 input logic              mw);
        @(negedge clk);
        reset        = rst;
        ex_control   = ctrl;
        ex_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = use1;
        id_use_rs2   = use2;
        branch_taken = br;
        mem_wait     = mw;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = {pc_en, if_id_en, if_id_flush, id_ex_en,
                    id_ex_bubble, ex_mem_en, ex_mem_bubble, mul_busy};
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    endtask

    task automatic checkStall(input string tag, input logic [31:0] expected);
        checks++;
        assert (stall_cycles === expected) passed++;
        else $error("[TB] FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, expected);
    endtask

    initial begin
        // Reset overrides a pending multiply and memory wait.
        applyStimulus(1, C_MUL, 5'd1, 5'd0, 5'd0, 0, 0, 1, 1);
        checkOutput("reset_outputs", E_DEF);
        applyStimulus(0, C_NONE, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("idle", E_DEF);
        checkStall("reset_count", 32'd0);

        applyStimulus(0, C_LOAD, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
        checkOutput("load_use_rs1", E_LU);
        applyStimulus(0, C_NONE, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
        checkOutput("load_use_cleared", E_DEF);
        checkStall("load_use_count", 32'd1);

        applyStimulus(0, C_LOAD, 5'd31, 5'd31, 5'd0, 1, 0, 0, 0);
        checkOutput("zero_reg_no_stall", E_DEF);
        applyStimulus(0, C_LOAD, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
        checkOutput("unused_rs1_no_stall", E_DEF);
        applyStimulus(0, C_LOAD, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0);
        checkOutput("load_use_rs2", E_LU);
        applyStimulus(0, C_NONE, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkStall("after_rs2_stall", 32'd2);

        // Plain multiply: 4 cycles in EX, branch ignored while busy.
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mul_c0", E_MUL0);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 1, 0);
        checkOutput("mul_c1_branch_ignored", E_MULB);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mul_c2", E_MULB);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mul_c3_release", E_REL);
        applyStimulus(0, C_NONE, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mul_after", E_DEF);
        checkStall("mul_count", 32'd5);

        // Multiply stretched by two memory-wait cycles.
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulmw_c0", E_MUL0);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulmw_c1", E_MULB);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 1);
        checkOutput("mulmw_c2_wait", E_MWB);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 1);
        checkOutput("mulmw_c3_wait", E_MWB);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulmw_c4", E_MULB);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulmw_c5_release", E_REL);
        applyStimulus(0, C_NONE, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulmw_after", E_DEF);
        checkStall("mulmw_count", 32'd10);

        applyStimulus(0, C_LOAD, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0);
        checkOutput("branch_over_load_use", E_BR);
        applyStimulus(0, C_LOAD, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1);
        checkOutput("mem_wait_over_load_use", E_MWR);
        applyStimulus(0, C_NONE, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkStall("branch_memwait_count", 32'd11);

        // Reset asserted in the middle of a multiply.
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulrst_c0", E_MUL0);
        applyStimulus(0, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulrst_c1", E_MULB);
        applyStimulus(1, C_MUL, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulrst_reset", E_DEF);
        applyStimulus(0, C_NONE, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        checkOutput("mulrst_after", E_DEF);
        checkStall("mulrst_count", 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller. It reads the EX-side outputs of the ID/EX register (control word, rd) and the ID-side source registers, and drives the enables, bubbles and flushes of the IF, IF/ID, ID/EX and EX/MEM stages. It covers load-use stalls, taken-branch flushes, multi-cycle multiply occupancy of EX, and data-memory wait freezes. It also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_CYCLES, 4, total cycles a multiply occupies EX; legal range 2..16.
CTRL_W, 14, width of the ID/EX control word.

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
ex_control  in  CTRL_W  ID/EX control_out; bit indices come from the package
ex_rd  in  5  ID/EX rd_out
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
branch_taken  in  1  branch resolved taken in EX this cycle
mem_wait  in  1  data memory not ready
pc_en  out  1  PC register enable
if_id_en  out  1  IF/ID enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_en  out  1  ID/EX enable
id_ex_bubble  out  1  ID/EX loads an all-zero control word
ex_mem_en  out  1  EX/MEM enable
ex_mem_bubble  out  1  EX/MEM loads an all-zero control word
mul_busy  out  1  high while in state MUL_BUSY
stall_cycles  out  32  count of cycles with pc_en=0, saturating

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: at a clk edge with reset=1, state<=RUN, cnt<=0, stall_cycles<=0.
- While reset=1, outputs are: all enables 1, all bubble and flush outputs 0, mul_busy 0.
- All enable, bubble and flush outputs are combinational from the state and the current inputs, so they take effect at the same edge.
- Definitions:
  - mul_ex = ex_control[MUL_BIT]
  - memrd_ex = ex_control[MEM_READ_BIT]
  - load_use = memrd_ex && ex_rd!=31 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))
  - X31 is the zero register and never causes a hazard.
- Default outputs: every enable 1, every bubble and flush 0.
- State RUN, evaluated in priority order:
  1. mem_wait=1: all four enables are 0 and nothing is bubbled or flushed. State and cnt hold.
  2. mul_ex=1: pc_en, if_id_en and id_ex_en are 0; ex_mem_bubble is 1. Load cnt<=MUL_CYCLES-2 and go to MUL_BUSY.
  3. branch_taken=1: if_id_flush=1 and id_ex_bubble=1; PC advances. Any load_use is ignored because the ID instruction is being discarded.
  4. load_use=1: pc_en and if_id_en are 0; id_ex_bubble=1 with id_ex_en still 1. This is a 1-cycle stall, which clears once the bubble enters EX.
- State MUL_BUSY: mul_busy=1 and branch_taken is ignored.
  - mem_wait=1: all enables are 0, cnt holds, state holds.
  - cnt!=0: same stall as the RUN multiply entry (pc, if_id and id_ex enables 0, ex_mem_bubble 1); cnt<=cnt-1.
  - cnt==0: release with default outputs, so EX/MEM captures the product and ID/EX advances. Go to RUN.
- The multiply therefore spends exactly MUL_CYCLES cycles in EX when no mem_wait occurs.
- A back-to-back multiply is re-detected in RUN and stalls again. There is no retrigger on the same instruction because ID/EX advanced on the release cycle.
- stall_cycles increments on every non-reset edge where pc_en=0 and saturates at 32'hFFFF_FFFF.
- Reset asserted during MUL_BUSY aborts to RUN on the next edge. The pipeline registers are reset in parallel.

Decomposition:
- Package hazard_pkg holds:
  - state enum {RUN, MUL_BUSY}
  - control bit index constants REG_WRITE_BIT=0, MEM_READ_BIT=3, MUL_BIT=9
  - ZERO_REG=5'd31
- One sub-module, mul_cycle_counter: a 4-bit loadable down-counter with a hold enable and a zero flag.

Test Plan:
- memrd_ex=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; the next cycle is all defaults; stall_cycles=1.
- Same stimulus as the previous case but ex_rd=31, or id_use_rs1=0 -> no stall.
- mul_ex=1 with MUL_CYCLES=4 -> pc_en=0 for cycles 0-2 and 1 at cycle 3; ex_mem_bubble=1 for cycles 0-2; mul_busy=1 for cycles 1-3; stall_cycles=3.
- mul_ex=1 with mem_wait=1 held 2 cycles during MUL_BUSY -> the multiply spans 6 cycles and cnt holds while mem_wait=1.
- branch_taken=1 together with load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_en=1.
- reset=1 at cycle 2 of a multiply -> the next cycle is RUN, mul_busy=0, stall_cycles=0, all enables 1.
